// File: rtl/vga_charmap_reader.sv
// VGA text-mode timing generator that reads a character map over a synchronous RAM port.
// Optional blink attribute via VGA_CHARMAP_READER_BLINK_EN.
module vga_charmap_reader #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned CHAR_W     = 8,
    parameter int unsigned CHAR_H     = 16,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    output logic [ADDR_WIDTH-1:0]      addr_o,
    input  logic [DATA_WIDTH-1:0]      data_i,
    output logic [DATA_WIDTH-1:0]      char_o,
    output logic [$clog2(CHAR_W)-1:0]  glyph_x_o,
    output logic [$clog2(CHAR_H)-1:0]  glyph_y_o,
    output logic                       de_o,
    output logic                       hsync_o,
    output logic                       vsync_o,
    output logic                       frame_start_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned GX_W    = $clog2(CHAR_W);
    localparam int unsigned GY_W    = $clog2(CHAR_H);
    localparam int unsigned COLS    = H_ACTIVE / CHAR_W;
    localparam int unsigned ROWS    = V_ACTIVE / CHAR_H;

    localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SB   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SE   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SB   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SE   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    if (64'(COLS) * 64'(ROWS) > (64'(1) << ADDR_WIDTH)) begin : g_grid_too_big
        $error("vga_charmap_reader: character grid exceeds 2**ADDR_WIDTH cells");
    end
    if (((CHAR_W & (CHAR_W - 1)) != 0) || ((CHAR_H & (CHAR_H - 1)) != 0)) begin : g_cell_not_pow2
        $error("vga_charmap_reader: CHAR_W and CHAR_H must be powers of two");
    end

    logic [H_W-1:0]        r_h_cnt;
    logic [V_W-1:0]        r_v_cnt;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [H_W-1:0]        w_h_nxt;
    logic [V_W-1:0]        w_v_nxt;
    logic [ADDR_WIDTH-1:0] w_rb_nxt;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic                  w_de;
    logic                  w_hs;
    logic                  w_vs;
    logic                  w_fs;
    logic [DATA_WIDTH-1:0] w_char;

    logic                  r_de1;
    logic                  r_hs1;
    logic                  r_vs1;
    logic                  r_fs1;
    logic [GX_W-1:0]       r_gx1;
    logic [GY_W-1:0]       r_gy1;

    // Next counter position; row base advances by one text row at each glyph-row boundary.
    always_comb begin
        w_h_nxt  = r_h_cnt + H_W'(1);
        w_v_nxt  = r_v_cnt;
        w_rb_nxt = r_row_base;
        if (r_h_cnt == H_LAST) begin
            w_h_nxt = '0;
            if (r_v_cnt == V_LAST) begin
                w_v_nxt  = '0;
                w_rb_nxt = '0;
            end else begin
                w_v_nxt = r_v_cnt + V_W'(1);
                if (&r_v_cnt[GY_W-1:0]) begin
                    w_rb_nxt = r_row_base + ADDR_WIDTH'(COLS);
                end
            end
        end
    end

    // Address is looked ahead one pixel so it is on the bus while the counters hold that pixel.
    assign w_addr_nxt = ((w_h_nxt < H_ACT) && (w_v_nxt < V_ACT))
                      ? w_rb_nxt + ADDR_WIDTH'(w_h_nxt >> GX_W) : '0;

    assign w_de = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign w_hs = !((r_h_cnt >= H_SB) && (r_h_cnt < H_SE));
    assign w_vs = !((r_v_cnt >= V_SB) && (r_v_cnt < V_SE));
    assign w_fs = (r_h_cnt == '0) && (r_v_cnt == '0);

`ifdef VGA_CHARMAP_READER_BLINK_EN
    logic [4:0] r_frame_cnt;
    logic       w_frame_wrap;

    assign w_frame_wrap = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_frame_cnt <= '0;
        end else if (w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
        end
    end

    // Codes with the top bit set disappear during the second half of each 32-frame period.
    assign w_char = (data_i[DATA_WIDTH-1] && r_frame_cnt[4]) ? '0 : data_i;
`else
    assign w_char = data_i;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_h_cnt    <= '0;
            r_v_cnt    <= '0;
            r_row_base <= '0;
            addr_o     <= '0;
        end else begin
            r_h_cnt    <= w_h_nxt;
            r_v_cnt    <= w_v_nxt;
            r_row_base <= w_rb_nxt;
            addr_o     <= w_addr_nxt;
        end
    end

    // Two-stage sideband pipeline so timing outputs line up with RAM data in char_o.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_de1         <= 1'b0;
            r_hs1         <= 1'b1;
            r_vs1         <= 1'b1;
            r_fs1         <= 1'b0;
            r_gx1         <= '0;
            r_gy1         <= '0;
            de_o          <= 1'b0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            frame_start_o <= 1'b0;
            glyph_x_o     <= '0;
            glyph_y_o     <= '0;
            char_o        <= '0;
        end else begin
            r_de1         <= w_de;
            r_hs1         <= w_hs;
            r_vs1         <= w_vs;
            r_fs1         <= w_fs;
            r_gx1         <= r_h_cnt[GX_W-1:0];
            r_gy1         <= r_v_cnt[GY_W-1:0];
            de_o          <= r_de1;
            hsync_o       <= r_hs1;
            vsync_o       <= r_vs1;
            frame_start_o <= r_fs1;
            glyph_x_o     <= r_gx1;
            glyph_y_o     <= r_gy1;
            char_o        <= r_de1 ? w_char : '0;
        end
    end

endmodule

// File: tb/tb_vga_charmap_reader.sv
// Scoreboard bench for vga_charmap_reader on a reduced 40x36 raster (32x32 visible, 4x2 glyph grid).
module tb_vga_charmap_reader;

    localparam int FRAME = 40 * 36;
`ifdef VGA_CHARMAP_READER_BLINK_EN
    localparam int     F_RST   = 33;
    localparam logic [15:0] CH_F16 = 16'h00;
`else
    localparam int     F_RST   = 17;
    localparam logic [15:0] CH_F16 = 16'h85;
`endif

    localparam int S_DE = 0, S_HS = 1, S_VS = 2, S_FS = 3, S_CH = 4, S_GX = 5, S_GY = 6, S_AD = 7;

    typedef struct {
        int          cyc;
        int          sel;
        logic [15:0] exp;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        arstn_i = 1'b1;
    logic [11:0] addr_o;
    logic [7:0]  data_i = 8'h00;
    logic [7:0]  char_o;
    logic [2:0]  glyph_x_o;
    logic [3:0]  glyph_y_o;
    logic        de_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        frame_start_o;

    logic [7:0]  mem [0:4095];
    vec_t        q[$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_blank_char = 0;
    string       sel_name [0:7] = '{"de_o", "hsync_o", "vsync_o", "frame_start_o",
                                    "char_o", "glyph_x_o", "glyph_y_o", "addr_o"};

    vga_charmap_reader #(
        .H_ACTIVE(32), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(32), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CHAR_W(8), .CHAR_H(16), .ADDR_WIDTH(12), .DATA_WIDTH(8)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i), .addr_o(addr_o), .data_i(data_i),
        .char_o(char_o), .glyph_x_o(glyph_x_o), .glyph_y_o(glyph_y_o),
        .de_o(de_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_start_o(frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    // Synchronous charmap RAM: one clock of read latency.
    always @(posedge clk_i) data_i <= mem[addr_o];

    // Edges since the most recent reset release.
    always @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic push(input int c, input int s, input logic [15:0] e);
        vec_t v;
        v.cyc = c; v.sel = s; v.exp = e;
        q.push_back(v);
    endtask

    task automatic push_reset_vals(input int c);
        push(c, S_DE, 16'd0); push(c, S_HS, 16'd1); push(c, S_VS, 16'd1); push(c, S_FS, 16'd0);
        push(c, S_CH, 16'd0); push(c, S_GX, 16'd0); push(c, S_GY, 16'd0); push(c, S_AD, 16'd0);
    endtask

    function automatic logic [15:0] actual(input int s);
        case (s)
            S_DE:    return 16'(de_o);
            S_HS:    return 16'(hsync_o);
            S_VS:    return 16'(vsync_o);
            S_FS:    return 16'(frame_start_o);
            S_CH:    return 16'(char_o);
            S_GX:    return 16'(glyph_x_o);
            S_GY:    return 16'(glyph_y_o);
            default: return 16'(addr_o);
        endcase
    endfunction

    // Monitor: pops every expectation due at this cycle and compares it with the DUT.
    always @(negedge clk_i) begin
        if (arstn_i && !de_o && char_o != 8'h00) n_blank_char++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            vec_t v;
            logic [15:0] a;
            v = q.pop_front();
            a = actual(v.sel);
            n_cmp++;
            if (v.cyc < cyc) begin
                n_bad++;
                $display("FAIL %s@%0d: expectation missed (now cycle %0d)", sel_name[v.sel], v.cyc, cyc);
            end else if (a !== v.exp) begin
                n_bad++;
                $display("FAIL %s@%0d: got 0x%0h, expected 0x%0h", sel_name[v.sel], v.cyc, a, v.exp);
            end
        end
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[0] = 8'h85;
        mem[5] = 8'h41;
        mem[7] = 8'h37;

        push_reset_vals(0);
        push(1, S_DE, 16'd0); push(1, S_FS, 16'd0); push(1, S_AD, 16'd0);
        push(2, S_FS, 16'd1); push(2, S_DE, 16'd1); push(2, S_CH, 16'h85);
        push(2, S_GX, 16'd0); push(2, S_GY, 16'd0); push(2, S_HS, 16'd1); push(2, S_VS, 16'd1);
        push(3, S_FS, 16'd0); push(3, S_DE, 16'd1); push(3, S_GX, 16'd1); push(3, S_CH, 16'h85);
        push(8, S_AD, 16'd1);
        push(9, S_GX, 16'd7); push(9, S_CH, 16'h85);
        push(10, S_GX, 16'd0); push(10, S_CH, 16'h00); push(10, S_DE, 16'd1);
        push(33, S_DE, 16'd1);
        push(34, S_DE, 16'd0); push(34, S_CH, 16'h00);
        push(35, S_HS, 16'd1); push(36, S_HS, 16'd0); push(39, S_HS, 16'd0); push(40, S_HS, 16'd1);
        push(42, S_DE, 16'd1); push(42, S_FS, 16'd0); push(42, S_CH, 16'h85); push(42, S_GY, 16'd1);
        push(624, S_AD, 16'd3); push(640, S_AD, 16'd4); push(648, S_AD, 16'd5);
        push(650, S_CH, 16'h41); push(650, S_GX, 16'd0); push(650, S_GY, 16'd0); push(650, S_DE, 16'd1);
        push(1257, S_CH, 16'h41); push(1257, S_GX, 16'd7); push(1257, S_GY, 16'd15);
        push(1258, S_CH, 16'h00); push(1258, S_GX, 16'd0);
        push(1271, S_AD, 16'd7); push(1272, S_AD, 16'd0);
        push(1273, S_CH, 16'h37); push(1273, S_DE, 16'd1);
        push(1274, S_DE, 16'd0); push(1274, S_CH, 16'h00);
        push(1280, S_AD, 16'd0); push(1282, S_DE, 16'd0); push(1282, S_CH, 16'h00);
        push(1321, S_VS, 16'd1); push(1322, S_VS, 16'd0); push(1401, S_VS, 16'd0); push(1402, S_VS, 16'd1);
        push(1441, S_FS, 16'd0); push(1442, S_FS, 16'd1); push(1442, S_CH, 16'h85); push(1443, S_FS, 16'd0);
        push(2882, S_FS, 16'd1); push(2882, S_CH, 16'h85);
        push(16 * FRAME + 2, S_FS, 16'd1); push(16 * FRAME + 2, S_CH, CH_F16);
        push(16 * FRAME + 650, S_CH, 16'h41);
`ifdef VGA_CHARMAP_READER_BLINK_EN
        push(31 * FRAME + 2, S_CH, 16'h00);
        push(32 * FRAME + 2, S_FS, 16'd1); push(32 * FRAME + 2, S_CH, 16'h85);
`endif

        #1 arstn_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1 arstn_i = 1'b1;

        // Run to pixel (20,20) of frame F_RST, then pulse reset mid-line.
        for (int i = 0; i < 60000 && cyc != F_RST * FRAME + 820; i++) @(negedge clk_i);
        if (cyc != F_RST * FRAME + 820) begin
            n_cmp++; n_bad++;
            $display("FAIL reset_trigger: reached cycle %0d, expected %0d", cyc, F_RST * FRAME + 820);
        end
        #1 arstn_i = 1'b0;
        push_reset_vals(0);
        push(1, S_DE, 16'd0); push(1, S_FS, 16'd0);
        push(2, S_FS, 16'd1); push(2, S_DE, 16'd1); push(2, S_CH, 16'h85);
        push(650, S_CH, 16'h41); push(650, S_GX, 16'd0); push(650, S_GY, 16'd0);
        push(1442, S_FS, 16'd1);
        repeat (3) @(negedge clk_i);
        #1 arstn_i = 1'b1;

        for (int i = 0; i < 4000 && q.size() != 0; i++) @(negedge clk_i);
        @(posedge clk_i);
        if (q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
        end
        n_cmp++;
        if (n_blank_char != 0) begin
            n_bad++;
            $display("FAIL blank_char: %0d blanking cycles with nonzero char_o, expected 0", n_blank_char);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
